fetch_prefetch: RTL

//   Parametrised instruction fetch unit with a prefetch buffer. It issues sequential

---
 rtl/fetch_prefetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_prefetch.sv | 118 +++++++++++
 3 files changed

// File: rtl/fetch_prefetch_pkg.sv
// Shared definitions for the instruction fetch / prefetch slice.
//   XLEN_DEFAULT          default address/data width
//   INST_BYTES            bytes per instruction (sequential PC step)
//   RESET_VECTOR_DEFAULT  default first fetch address after reset
//   DEPTH_DEFAULT         default prefetch buffer depth
//   cnt_width()           width of counters that must hold 0..depth
package fetch_prefetch_pkg;

    localparam int unsigned XLEN_DEFAULT         = 32;
    localparam int unsigned INST_BYTES           = 4;
    localparam int unsigned DEPTH_DEFAULT        = 4;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries for the prefetch buffer.
//   clk, rst_n   clock, synchronous active-low reset
//   clear        drop all entries (wins over push/pop)
//   push, wdata  write one entry
//   pop, rdata   remove head; rdata always shows the current head
//   full, empty  occupancy flags
//   count        current number of entries (0..DEPTH)
module fetch_fifo
    import fetch_prefetch_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        push,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        pop,
    output logic [WIDTH-1:0]            rdata,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage is not reset; validity is tracked purely by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch unit with an in-order prefetch buffer.
//   CLK, RST_N                    clock, synchronous active-low reset
//   FLUSH, FLUSH_PC               redirect: drop buffer and stale reads, restart at FLUSH_PC
//   INST_RDEN, INST_RIADDR        read request and address (registered)
//   INST_RGNT                     memory accepts the pending request
//   INST_RVALID, INST_RDATA       in-order read responses
//   OUT_VALID, OUT_PC, OUT_INST   buffer head towards decode
//   OUT_READY                     decode consumes the head
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEFAULT,
    parameter int unsigned     DEPTH        = DEPTH_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            FLUSH,
    input  logic [XLEN-1:0] FLUSH_PC,
    output logic            INST_RDEN,
    output logic [XLEN-1:0] INST_RIADDR,
    input  logic            INST_RGNT,
    input  logic            INST_RVALID,
    input  logic [XLEN-1:0] INST_RDATA,
    output logic            OUT_VALID,
    output logic [XLEN-1:0] OUT_PC,
    output logic [XLEN-1:0] OUT_INST,
    input  logic            OUT_READY
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned SW = CW + 1;

    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard;
    logic [XLEN-1:0]   resp_pc;

    logic              accept;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [2*XLEN-1:0] fifo_head;

    logic [CW-1:0]     outstanding_nxt;
    logic [CW-1:0]     occ_nxt;
    logic              credit_ok;

    assign accept    = INST_RDEN && INST_RGNT;
    // A response is buffered only outside a flush and once all stale reads are gone.
    assign fifo_push = INST_RVALID && !FLUSH && (discard == '0);
    assign OUT_VALID = !fifo_empty && !FLUSH;
    assign fifo_pop  = OUT_VALID && OUT_READY;
    assign OUT_PC    = fifo_head[2*XLEN-1:XLEN];
    assign OUT_INST  = fifo_head[XLEN-1:0];

    // Credit looks at next-cycle occupancy and in-flight count so the buffer
    // always has room for every outstanding read.
    always_comb begin
        outstanding_nxt = outstanding + CW'(accept) - CW'(INST_RVALID);
        occ_nxt         = '0;
        if (!FLUSH) begin
            occ_nxt = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
        end
        credit_ok = (SW'(occ_nxt) + SW'(outstanding_nxt)) < SW'(DEPTH);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            INST_RDEN   <= 1'b0;
            INST_RIADDR <= RESET_VECTOR;
            outstanding <= '0;
            discard     <= '0;
            resp_pc     <= RESET_VECTOR;
        end else begin
            INST_RDEN   <= credit_ok;
            outstanding <= outstanding_nxt;
            if (FLUSH) begin
                // Everything still in flight after this edge belongs to the old stream.
                INST_RIADDR <= FLUSH_PC;
                resp_pc     <= FLUSH_PC;
                discard     <= outstanding_nxt;
            end else begin
                if (accept) begin
                    INST_RIADDR <= INST_RIADDR + XLEN'(INST_BYTES);
                end
                if (INST_RVALID) begin
                    if (discard != '0) begin
                        discard <= discard - CW'(1);
                    end else begin
                        resp_pc <= resp_pc + XLEN'(INST_BYTES);
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .clear (FLUSH),
        .push  (fifo_push),
        .wdata ({resp_pc, INST_RDATA}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    a_no_overflow : assert property (@(posedge CLK) disable iff (!RST_N)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule
